// File: rtl/clock_set_controller.sv
// Digital clock mode/time-setting controller: two conditioned push buttons, a 1 s
// prescaler, and a RUN/SET_HR/SET_MIN FSM driving the HH:MM:SS counters.

module btn_cond #(
  parameter int DEBOUNCE_CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync;
  logic          lvl, lvl_d;
  logic [CW-1:0] cnt;

  // Flip on the DEBOUNCE_CYC-th consecutive mismatching cycle, so cnt never holds DEBOUNCE_CYC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], raw};
      lvl_d <= lvl;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = lvl & ~lvl_d;
endmodule

module clock_set_controller #(
  parameter int TICK_DIV     = 5_000_000,
  parameter int DEBOUNCE_CYC = 50_000
) (
  input  logic       clk_5MHz,
  input  logic       i_rst,
  input  logic       i_mode_btn,
  input  logic       i_inc_btn,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_mode,
  output logic       o_tick,
  output logic       o_blink
);
  localparam int NUM_BTN = 2;
  localparam int PW      = $clog2(TICK_DIV);
  localparam int HALF    = TICK_DIV / 2;
  localparam int BW      = (HALF > 2) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_BTN-1:0]   raw_btn, press;
  logic                 mode_p, inc_p;
  logic [PW-1:0]        presc;
  logic [BW-1:0]        bcnt;

  assign raw_btn = {i_inc_btn, i_mode_btn};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk  (clk_5MHz),
      .rst  (i_rst),
      .raw  (raw_btn[i]),
      .press(press[i])
    );
  end

  assign mode_p = press[0];
  assign inc_p  = press[1] & ~press[0];

  always_ff @(posedge clk_5MHz or posedge i_rst) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_p) begin
      case (state)
        RUN:     state_nxt = SET_HR;
        SET_HR:  state_nxt = SET_MIN;
        default: state_nxt = RUN;
      endcase
    end
  end

  assign o_mode = state;

  always_ff @(posedge clk_5MHz or posedge i_rst) begin
    if (i_rst) begin
      o_hour  <= '0;
      o_min   <= '0;
      o_sec   <= '0;
      o_tick  <= 1'b0;
      o_blink <= 1'b0;
      presc   <= '0;
      bcnt    <= '0;
    end else begin
      o_tick <= 1'b0;
      if (mode_p) begin
        presc   <= '0;
        bcnt    <= '0;
        o_blink <= (state_nxt != RUN);
        if (state == SET_MIN) o_sec <= '0;
      end else begin
        case (state)
          RUN: begin
            o_blink <= 1'b0;
            bcnt    <= '0;
            if (presc == PW'(TICK_DIV - 1)) begin
              presc  <= '0;
              o_tick <= 1'b1;
              if (o_sec == 6'd59) begin
                o_sec <= '0;
                if (o_min == 6'd59) begin
                  o_min  <= '0;
                  o_hour <= (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
                end else begin
                  o_min <= o_min + 6'd1;
                end
              end else begin
                o_sec <= o_sec + 6'd1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: begin
            if (bcnt == BW'(HALF - 1)) begin
              bcnt    <= '0;
              o_blink <= ~o_blink;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
            if (inc_p && state == SET_HR)
              o_hour <= (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
            if (inc_p && state == SET_MIN)
              o_min <= (o_min == 6'd59) ? 6'd0 : o_min + 6'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: vector table for setting sequences plus
// hand-timed sequences for tick, debounce latency, blink and async reset.

module tb_clock_set_controller;
  localparam int TD = 10;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [4:0] hr;
  logic [5:0] mn, sc;
  logic [1:0] mode;
  logic       tick, blink;

  int total = 0;
  int bad = 0;
  int set_ticks = 0;
  int run_blinks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit         m;
    int         n_inc;
    logic [1:0] e_mode;
    logic [4:0] e_hour;
    logic [5:0] e_min;
  } vec_t;

  vec_t vt[9];
  int   bh[6] = '{1, 3, 2, 3, 1, 2};
  int   bl[6] = '{2, 1, 3, 1, 2, 3};

  always #100 clk = ~clk;

  clock_set_controller #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC)) dut (
    .clk_5MHz  (clk),
    .i_rst     (rst),
    .i_mode_btn(mode_btn),
    .i_inc_btn (inc_btn),
    .o_hour    (hr),
    .o_min     (mn),
    .o_sec     (sc),
    .o_mode    (mode),
    .o_tick    (tick),
    .o_blink   (blink)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (mode != 2'd0 && tick) set_ticks++;
      if (mode == 2'd0 && blink) run_blinks++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit m, input bit i);
    if (m) mode_btn = 1'b1;
    if (i) inc_btn = 1'b1;
    cyc(8);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    cyc(8);
  endtask

  task automatic do_reset();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{0, 1,  2'd0, 5'd0,  6'd0};
    vt[1] = '{1, 0,  2'd1, 5'd0,  6'd0};
    vt[2] = '{0, 23, 2'd1, 5'd23, 6'd0};
    vt[3] = '{0, 1,  2'd1, 5'd0,  6'd0};
    vt[4] = '{0, 23, 2'd1, 5'd23, 6'd0};
    vt[5] = '{1, 0,  2'd2, 5'd23, 6'd0};
    vt[6] = '{0, 59, 2'd2, 5'd23, 6'd59};
    vt[7] = '{0, 1,  2'd2, 5'd23, 6'd0};
    vt[8] = '{0, 59, 2'd2, 5'd23, 6'd59};

    // reset state and first tick
    cyc(2);
    chk("rst_hour", hr, 0);
    chk("rst_min", mn, 0);
    chk("rst_sec", sc, 0);
    chk("rst_mode", mode, 0);
    chk("rst_tick", tick, 0);
    chk("rst_blink", blink, 0);
    rst = 1'b0;
    cyc(9);
    chk("tick_before_10", tick, 0);
    cyc(1);
    chk("tick_at_10", tick, 1);
    chk("sec_at_10", sc, 1);
    cyc(1);
    chk("tick_one_cycle", tick, 0);
    cyc(589);
    chk("min_at_600", mn, 1);
    chk("sec_at_600", sc, 0);
    chk("hour_at_600", hr, 0);

    // table-driven setting sequence
    do_reset();
    mon_en = 1'b1;
    for (int v = 0; v < 9; v++) begin
      if (vt[v].m) press(1'b1, 1'b0);
      for (int k = 0; k < vt[v].n_inc; k++) press(1'b0, 1'b1);
      chk($sformatf("vec%0d_mode", v), mode, vt[v].e_mode);
      chk($sformatf("vec%0d_hour", v), hr, vt[v].e_hour);
      chk($sformatf("vec%0d_min", v), mn, vt[v].e_min);
    end
    chk("sec_frozen", sc, 2);

    // SET_MIN -> RUN, then roll over 23:59 -> 00:00:00
    mode_btn = 1'b1;
    cyc(6);
    chk("run_entry_early", mode, 2);
    cyc(1);
    chk("run_entry_mode", mode, 0);
    chk("run_entry_sec", sc, 0);
    chk("run_entry_blink", blink, 0);
    cyc(9);
    chk("run_tick_early", tick, 0);
    cyc(1);
    chk("run_tick_first", tick, 1);
    chk("run_sec_first", sc, 1);
    mode_btn = 1'b0;
    cyc(590);
    chk("wrap_hour", hr, 0);
    chk("wrap_min", mn, 0);
    chk("wrap_sec", sc, 0);
    chk("wrap_mode", mode, 0);
    mon_en = 1'b0;
    chk("ticks_in_set", set_ticks, 0);
    chk("blink_in_run", run_blinks, 0);

    // bounce rejection and clean press latency in SET_HR
    do_reset();
    press(1'b1, 1'b0);
    for (int b = 0; b < 6; b++) begin
      inc_btn = 1'b1;
      cyc(bh[b]);
      inc_btn = 1'b0;
      cyc(bl[b]);
    end
    cyc(8);
    chk("bounce_hour", hr, 0);
    inc_btn = 1'b1;
    cyc(6);
    chk("clean_edge6", hr, 0);
    cyc(1);
    chk("clean_edge7", hr, 1);
    cyc(3);
    inc_btn = 1'b0;
    cyc(12);
    chk("clean_once", hr, 1);

    // blink behaviour across mode sequence
    do_reset();
    chk("m4_mode0", mode, 0);
    chk("m4_blink0", blink, 0);
    mode_btn = 1'b1;
    cyc(7);
    chk("m4_mode1", mode, 1);
    chk("m4_blink_enter1", blink, 1);
    cyc(4);
    chk("m4_blink_4", blink, 1);
    cyc(1);
    chk("m4_blink_5", blink, 0);
    cyc(4);
    chk("m4_blink_9", blink, 0);
    cyc(1);
    chk("m4_blink_10", blink, 1);
    mode_btn = 1'b0;
    cyc(10);
    mode_btn = 1'b1;
    cyc(7);
    chk("m4_mode2", mode, 2);
    chk("m4_blink_enter2", blink, 1);
    cyc(5);
    chk("m4_blink2_5", blink, 0);
    mode_btn = 1'b0;
    cyc(10);
    press(1'b1, 1'b0);
    chk("m4_mode_back0", mode, 0);
    chk("m4_blink_run", blink, 0);

    // simultaneous mode and inc in SET_HR
    do_reset();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("sim_pre_hour", hr, 2);
    press(1'b1, 1'b1);
    chk("sim_mode", mode, 2);
    chk("sim_hour", hr, 2);
    chk("sim_min", mn, 0);

    // async reset in SET_MIN at 12:34, button held through reset
    do_reset();
    press(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int k = 0; k < 34; k++) press(1'b0, 1'b1);
    chk("pre_rst_hour", hr, 12);
    chk("pre_rst_min", mn, 34);
    chk("pre_rst_mode", mode, 2);
    @(posedge clk);
    #50 rst = 1'b1;
    #1;
    chk("async_hour", hr, 0);
    chk("async_min", mn, 0);
    chk("async_sec", sc, 0);
    chk("async_mode", mode, 0);
    chk("async_blink", blink, 0);
    chk("async_tick", tick, 0);
    mode_btn = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("held_edge6", mode, 0);
    cyc(1);
    chk("held_edge7", mode, 1);
    cyc(20);
    chk("held_once", mode, 1);
    mode_btn = 1'b0;
    cyc(10);
    chk("held_release", mode, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
